// File: rtl/tff_toggle_seq.sv
// tff_toggle_seq: programmable t-pulse generator driving a negedge T flip-flop stage
module tff_toggle_seq #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] presc;
  logic             cont;
  logic             fire;
  logic             last;
  assign fire = presc == '0;
  assign last = !cont && remaining == CNT_W'(1);
  // Sequencer: a pulse fires whenever the prescaler reaches zero; the final finite pulse parks in DONE for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      period    <= '0;
      presc     <= '0;
      cont      <= 1'b0;
      t         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE) begin
      t    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      if (start && !abort) begin
        state     <= RUN;
        busy      <= 1'b1;
        period    <= div;
        presc     <= div;
        remaining <= burst;
        cont      <= burst == '0;
      end
    end else if (state == RUN) begin
      if (abort) begin
        state     <= IDLE;
        t         <= 1'b0;
        busy      <= 1'b0;
        remaining <= '0;
      end else if (fire) begin
        t     <= 1'b1;
        presc <= period;
        if (!cont) remaining <= remaining - CNT_W'(1);
        if (last) state <= DONE;
      end else begin
        t     <= 1'b0;
        presc <= presc - DIV_W'(1);
      end
    end else begin
      state <= IDLE;
      t     <= 1'b0;
      busy  <= 1'b0;
      done  <= state == DONE;
    end
  end
endmodule
